// File: rtl/nn_stage_if.sv
// rtl/nn_stage_if.sv - stream, coefficient and configuration bundle of the nn_stage neuron
interface nn_stage_if;
    logic [2:0]  load_length;
    logic [3:0]  load_depth;
    logic [2:0]  bias_length;
    logic        state_length;
    logic [31:0] st_data;
    logic        st_data_vld;
    logic        st_data_fst;
    logic        st_data_rdy;
    logic [31:0] st_data_out;
    logic        st_data_out_vld;
    logic        st_data_out_fst;
    logic        st_data_out_rdy;
    logic [31:0] st_data_out_pre;
    logic        st_data_out_pre_vld;
    logic        st_data_out_pre_fst;
    logic        st_data_out_pre_rdy;
    logic [31:0] st_error;
    logic        st_error_vld;
    logic        st_error_fst;
    logic        st_error_rdy;
    logic [31:0] tap_in;
    logic        tap_in_vld;
    logic        tap_in_fst;
    logic        tap_in_rdy;
    logic [3:0]  tap_address;
    logic [2:0]  bias_address;

    modport slave (
        input  load_length, load_depth, bias_length, state_length,
        input  st_data, st_data_vld, st_data_fst, st_data_out_rdy, st_data_out_pre_rdy,
        input  st_error, st_error_vld, st_error_fst, tap_in, tap_in_vld, tap_in_fst,
        output st_data_rdy, st_data_out, st_data_out_vld, st_data_out_fst,
        output st_data_out_pre, st_data_out_pre_vld, st_data_out_pre_fst,
        output st_error_rdy, tap_in_rdy, tap_address, bias_address
    );

    modport master (
        output load_length, load_depth, bias_length, state_length,
        output st_data, st_data_vld, st_data_fst, st_data_out_rdy, st_data_out_pre_rdy,
        output st_error, st_error_vld, st_error_fst, tap_in, tap_in_vld, tap_in_fst,
        input  st_data_rdy, st_data_out, st_data_out_vld, st_data_out_fst,
        input  st_data_out_pre, st_data_out_pre_vld, st_data_out_pre_fst,
        input  st_error_rdy, tap_in_rdy, tap_address, bias_address
    );
endinterface

// File: rtl/nn_stage.sv
// rtl/nn_stage.sv - float_24_8 fully-connected neuron: MAC over a sample vector, bias add, optional ReLU
module nn_stage #(
    parameter int WMEM_DEPTH = 16,
    parameter int BMEM_DEPTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    nn_stage_if.slave bus
);
    typedef enum logic [1:0] {LD_WGT, LD_BIAS, LD_IDLE} ld_state_e;

    function automatic logic [31:0] f_pack(input logic s, input logic signed [9:0] e,
                                           input logic [22:0] m, input logic g, input logic st);
        logic [23:0]        mr;
        logic signed [9:0]  er;
        mr = {1'b0, m} + {23'b0, (g & (st | m[0]))};
        er = e + $signed({9'b0, mr[23]});
        if (er >= 10'sd255) return {s, 8'hFE, 23'h7FFFFF};
        if (er <= 10'sd0)   return 32'h0;
        return {s, er[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0]       p;
        logic signed [9:0] e;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
        if (p[47]) return f_pack(a[31] ^ b[31], e + 10'sd1, p[46:24], p[23], |p[22:0]);
        return f_pack(a[31] ^ b[31], e, p[45:23], p[22], |p[21:0]);
    endfunction

    function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       lg, sm;
        logic [7:0]        d;
        logic [5:0]        sh;
        logic [49:0]       mb_w;
        logic [26:0]       ma_x, mb_x, n;
        logic [27:0]       s28;
        logic [4:0]        msb;
        logic signed [9:0] e;
        if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? 32'h0 : b;
        if (b[30:23] == 8'd0) return a;
        if (b[30:0] > a[30:0]) begin
            lg = b; sm = a;
        end else begin
            lg = a; sm = b;
        end
        d    = lg[30:23] - sm[30:23];
        sh   = (d > 8'd49) ? 6'd49 : d[5:0];
        // two extra bits plus a sticky bit keep the aligned addend exact enough for RNE
        mb_w = {1'b1, sm[22:0], 26'b0} >> sh;
        mb_x = {mb_w[49:24], |mb_w[23:0]};
        ma_x = {1'b1, lg[22:0], 3'b0};
        s28  = (lg[31] == sm[31]) ? ({1'b0, ma_x} + {1'b0, mb_x}) : ({1'b0, ma_x} - {1'b0, mb_x});
        e    = $signed({2'b0, lg[30:23]});
        if (s28[27]) begin
            n = {s28[27:2], s28[1] | s28[0]};
            e = e + 10'sd1;
        end else begin
            msb = 5'd0;
            for (int k = 0; k < 27; k++) if (s28[k]) msb = 5'(k);
            n = s28[26:0] << (5'd26 - msb);
            e = e - $signed({5'b0, 5'd26 - msb});
        end
        if (!n[26]) return 32'h0;
        return f_pack(lg[31], e, n[25:3], n[2], n[1] | n[0]);
    endfunction

    ld_state_e   st_q, st_d, st_eff;
    logic [3:0]  ta_q, waddr;
    logic [2:0]  bw_q, baddr, b_max;
    logic        w_we, b_we, restart;
    logic [31:0] wmem_q [WMEM_DEPTH];
    logic [31:0] bmem_q [BMEM_DEPTH];

    logic [2:0]  cnt_q, j_q, i_eff, n_max, j_next;
    logic [31:0] acc_q, pre_q, out_q, prod, mac, pre_new, out_new;
    logic        fst_q, out_vld_q, pre_vld_q, fire, last;
    logic [32:0] err_unused_q;

    assign restart = bus.tap_in_vld & bus.tap_in_fst;
    assign st_eff  = restart ? LD_WGT : st_q;
    assign waddr   = restart ? 4'd0 : ta_q;
    assign baddr   = restart ? 3'd0 : bw_q;
    assign b_max   = (bus.bias_length == 3'd0) ? 3'd0 : bus.bias_length - 3'd1;

    always_ff @(posedge clk) begin
        if (reset) st_q <= LD_WGT;
        else       st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        if (bus.tap_in_vld) begin
            case (st_eff)
                LD_WGT:  st_d = (waddr == bus.load_depth) ? LD_BIAS : LD_WGT;
                LD_BIAS: st_d = (baddr == b_max) ? LD_IDLE : LD_BIAS;
                default: st_d = LD_IDLE;
            endcase
        end
    end

    always_comb begin
        w_we             = bus.tap_in_vld && (st_eff == LD_WGT);
        b_we             = bus.tap_in_vld && (st_eff == LD_BIAS);
        bus.bias_address = (st_q == LD_BIAS) ? bw_q : j_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ta_q <= '0;
            bw_q <= '0;
            for (int k = 0; k < WMEM_DEPTH; k++) wmem_q[k] <= '0;
            for (int k = 0; k < BMEM_DEPTH; k++) bmem_q[k] <= '0;
        end else begin
            if (w_we) begin
                wmem_q[waddr] <= bus.tap_in;
                ta_q          <= waddr + 4'd1;
                bw_q          <= '0;
            end
            if (b_we) begin
                bmem_q[baddr] <= bus.tap_in;
                bw_q          <= baddr + 3'd1;
            end
        end
    end

    assign bus.tap_in_rdy   = 1'b1;
    assign bus.tap_address  = ta_q;
    assign bus.st_error_rdy = 1'b1;

    // a new result can only be accepted once both result registers have drained
    assign bus.st_data_rdy = !(out_vld_q | pre_vld_q);
    assign fire    = bus.st_data_vld & bus.st_data_rdy;
    assign i_eff   = bus.st_data_fst ? 3'd0 : cnt_q;
    assign n_max   = (bus.load_length == 3'd0) ? 3'd0 : bus.load_length - 3'd1;
    assign last    = (i_eff == n_max);
    assign j_next  = (j_q >= b_max) ? 3'd0 : j_q + 3'd1;
    assign prod    = f_mul(bus.st_data, wmem_q[{1'b0, i_eff}]);
    assign mac     = f_add((i_eff == 3'd0) ? 32'h0 : acc_q, prod);
    assign pre_new = f_add(mac, bmem_q[j_q]);
    assign out_new = (bus.state_length && pre_new[31] && (pre_new[30:0] != 31'd0)) ? 32'h0 : pre_new;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            j_q          <= '0;
            acc_q        <= '0;
            pre_q        <= '0;
            out_q        <= '0;
            fst_q        <= 1'b0;
            out_vld_q    <= 1'b0;
            pre_vld_q    <= 1'b0;
            err_unused_q <= '0;
        end else begin
            if (bus.st_error_vld) err_unused_q <= {bus.st_error_fst, bus.st_error};
            if (out_vld_q && bus.st_data_out_rdy)     out_vld_q <= 1'b0;
            if (pre_vld_q && bus.st_data_out_pre_rdy) pre_vld_q <= 1'b0;
            if (fire) begin
                if (last) begin
                    cnt_q     <= '0;
                    pre_q     <= pre_new;
                    out_q     <= out_new;
                    fst_q     <= (j_q == 3'd0);
                    j_q       <= j_next;
                    out_vld_q <= 1'b1;
                    pre_vld_q <= 1'b1;
                end else begin
                    cnt_q <= i_eff + 3'd1;
                    acc_q <= mac;
                end
            end
        end
    end

    assign bus.st_data_out         = out_q;
    assign bus.st_data_out_vld     = out_vld_q;
    assign bus.st_data_out_fst     = fst_q;
    assign bus.st_data_out_pre     = pre_q;
    assign bus.st_data_out_pre_vld = pre_vld_q;
    assign bus.st_data_out_pre_fst = fst_q;
endmodule

// File: tb/tb_nn_stage.sv
// tb/tb_nn_stage.sv - directed bench for nn_stage with a real-arithmetic reference model
module tb_nn_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nn_stage_if bus();
    nn_stage #(.WMEM_DEPTH(16), .BMEM_DEPTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic real to_r(input logic [31:0] f);
        real v;
        if (f[30:23] == 8'd0) return 0.0;
        v = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (real'(f[30:23]) - 127.0));
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] to_f(input real v);
        real a, m, fr;
        int e, mi;
        logic s;
        logic [7:0] be;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m  = a * 8388608.0;
        mi = $rtoi(m);
        fr = m - real'(mi);
        if (fr > 0.5 || (fr == 0.5 && mi[0])) mi++;
        if (mi == 16777216) begin mi = 8388608; e++; end
        if (e + 127 >= 255) return {s, 8'hFE, 23'h7FFFFF};
        if (e + 127 <= 0) return 32'h0;
        be = 8'(e + 127);
        return {s, be, mi[22:0]};
    endfunction

    function automatic real rnd(input real v);
        return to_r(to_f(v));
    endfunction

    // reference model state
    logic [31:0] wm [16];
    logic [31:0] bm [8];
    real         acc_m, tmp_r;
    int          i_m, j_m, tcount, n_m, b_m, d_m, ie;
    bit          ev_out, ev_pre, e_fst, mvalid, prev_v, take, done;
    logic [31:0] e_pre, e_out;
    logic [64:0] got [$];

    initial begin
        mvalid = 0;
        prev_v = 0;
        forever begin
            @(negedge clk);
            n_m = (bus.load_length == 3'd0) ? 1 : int'(bus.load_length);
            b_m = (bus.bias_length == 3'd0) ? 1 : int'(bus.bias_length);
            d_m = int'(bus.load_depth);
            if (mvalid) begin
                chk("st_data_rdy", 32'(bus.st_data_rdy), 32'(!(ev_out || ev_pre)));
                chk("out_vld", 32'(bus.st_data_out_vld), 32'(ev_out));
                chk("pre_vld", 32'(bus.st_data_out_pre_vld), 32'(ev_pre));
                if (ev_out) begin
                    chk("out_data", bus.st_data_out, e_out);
                    chk("out_fst", 32'(bus.st_data_out_fst), 32'(e_fst));
                end
                if (ev_pre) begin
                    chk("pre_data", bus.st_data_out_pre, e_pre);
                    chk("pre_fst", 32'(bus.st_data_out_pre_fst), 32'(e_fst));
                end
                chk("tap_in_rdy", 32'(bus.tap_in_rdy), 1);
                chk("st_error_rdy", 32'(bus.st_error_rdy), 1);
                if (tcount > d_m && tcount <= d_m + b_m)
                    chk("bias_address_ld", 32'(bus.bias_address), 32'(tcount - d_m - 1));
                else
                    chk("bias_address_j", 32'(bus.bias_address), 32'(j_m));
                if (tcount <= d_m) chk("tap_address", 32'(bus.tap_address), 32'(tcount));
                if (bus.st_data_out_vld && !prev_v)
                    got.push_back({bus.st_data_out_pre, bus.st_data_out, bus.st_data_out_fst});
            end
            prev_v = bus.st_data_out_vld;
            if (reset) begin
                for (int k = 0; k < 16; k++) wm[k] = 32'h0;
                for (int k = 0; k < 8; k++) bm[k] = 32'h0;
                acc_m = 0.0; i_m = 0; j_m = 0; tcount = 0;
                ev_out = 0; ev_pre = 0; e_fst = 0; e_pre = 0; e_out = 0;
                mvalid = 1;
            end else begin
                take = bus.st_data_vld && !(ev_out || ev_pre);
                done = 0;
                if (ev_out && bus.st_data_out_rdy) ev_out = 0;
                if (ev_pre && bus.st_data_out_pre_rdy) ev_pre = 0;
                if (take) begin
                    ie = bus.st_data_fst ? 0 : i_m;
                    tmp_r = rnd(((ie == 0) ? 0.0 : acc_m) + to_r(bus.st_data) * to_r(wm[ie]));
                    if (ie == n_m - 1) begin
                        e_pre = to_f(tmp_r + to_r(bm[j_m]));
                        e_out = (bus.state_length && to_r(e_pre) < 0.0) ? 32'h0 : e_pre;
                        e_fst = (j_m == 0);
                        j_m   = (j_m + 1) % b_m;
                        i_m   = 0;
                        done  = 1;
                    end else begin
                        acc_m = tmp_r;
                        i_m   = ie + 1;
                    end
                end
                if (done) begin ev_out = 1; ev_pre = 1; end
                if (bus.tap_in_vld) begin
                    if (bus.tap_in_fst) tcount = 0;
                    if (tcount <= d_m) wm[tcount] = bus.tap_in;
                    else if (tcount <= d_m + b_m) bm[tcount - d_m - 1] = bus.tap_in;
                    if (tcount < 100) tcount++;
                end
            end
        end
    end

    logic [31:0] btab [5];
    logic [31:0] exp_t3 [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [31:0] w);
        for (int k = 0; k < 8; k++) begin
            bus.tap_in = w; bus.tap_in_vld = 1'b1; bus.tap_in_fst = (k == 0);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            bus.tap_in = btab[k]; bus.tap_in_vld = 1'b1; bus.tap_in_fst = 1'b0;
            tick();
        end
        bus.tap_in_vld = 1'b0;
    endtask

    task automatic send(input logic [31:0] x, input logic f);
        bit ok, r;
        ok = 0;
        bus.st_data = x; bus.st_data_fst = f; bus.st_data_vld = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            r = bus.st_data_rdy;
            tick();
            if (r) ok = 1;
        end
        bus.st_data_vld = 1'b0; bus.st_data_fst = 1'b0;
        chk("send_accept", 32'(ok), 1);
    endtask

    task automatic vec(input logic [31:0] x);
        send(x, 1'b1);
        for (int k = 0; k < 4; k++) send(x, 1'b0);
    endtask

    task automatic wait_res(input int n);
        for (int k = 0; k < 100 && got.size() < n; k++) tick();
        chk("result_count", 32'(got.size()), 32'(n));
    endtask

    task automatic chk_got(input int idx, input logic [31:0] pre, input logic [31:0] out, input logic f);
        logic [64:0] g;
        g = got[idx];
        chk("lit_pre", g[64:33], pre);
        chk("lit_out", g[32:1], out);
        chk("lit_fst", 32'(g[0]), 32'(f));
    endtask

    initial begin
        bus.load_length = 3'd5; bus.load_depth = 4'd7; bus.bias_length = 3'd5; bus.state_length = 1'b1;
        bus.st_data = 0; bus.st_data_vld = 0; bus.st_data_fst = 0;
        bus.st_data_out_rdy = 1; bus.st_data_out_pre_rdy = 1;
        bus.st_error = 0; bus.st_error_vld = 0; bus.st_error_fst = 0;
        bus.tap_in = 0; bus.tap_in_vld = 0; bus.tap_in_fst = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_vld", 32'(bus.st_data_out_vld), 0);
        chk("rst_pre_vld", 32'(bus.st_data_out_pre_vld), 0);
        chk("rst_out", bus.st_data_out, 0);
        chk("rst_pre", bus.st_data_out_pre, 0);
        chk("rst_tap_address", 32'(bus.tap_address), 0);
        chk("rst_bias_address", 32'(bus.bias_address), 0);
        chk("model_5p5", to_f(5.5), 32'h40B00000);
        chk("model_m4p5", to_f(-4.5), 32'hC0900000);

        // load then forward
        for (int k = 0; k < 5; k++) btab[k] = 32'h3F000000;
        load(32'h3F800000);
        bus.st_error = 32'hDEADBEEF; bus.st_error_vld = 1; bus.st_error_fst = 1;
        tick();
        bus.st_error_vld = 0; bus.st_error_fst = 0;
        vec(32'h3F800000);
        wait_res(1);
        chk_got(0, 32'h40B00000, 32'h40B00000, 1'b1);

        // ReLU and identity
        do_reset();
        load(32'hBF800000);
        vec(32'h3F800000);
        wait_res(2);
        chk_got(1, 32'hC0900000, 32'h00000000, 1'b1);
        bus.state_length = 1'b0;
        vec(32'h3F800000);
        wait_res(3);
        chk_got(2, 32'hC0900000, 32'hC0900000, 1'b0);
        bus.state_length = 1'b1;

        // bias cycling
        do_reset();
        btab[0] = 32'h00000000; btab[1] = 32'h3F800000; btab[2] = 32'h40000000;
        btab[3] = 32'h40400000; btab[4] = 32'h40800000;
        for (int k = 0; k < 5; k++) exp_t3[k] = btab[k];
        exp_t3[5] = 32'h00000000;
        load(32'h00000000);
        for (int v = 0; v < 6; v++) vec(32'h3F800000);
        wait_res(9);
        for (int v = 0; v < 6; v++) chk_got(3 + v, exp_t3[v], exp_t3[v], (v == 0 || v == 5));

        // backpressure
        do_reset();
        for (int k = 0; k < 5; k++) btab[k] = 32'h3F000000;
        load(32'h3F800000);
        bus.st_data_out_rdy = 0; bus.st_data_out_pre_rdy = 0;
        vec(32'h3F800000);
        bus.st_data = 32'h3F800000; bus.st_data_fst = 1; bus.st_data_vld = 1;
        tick();
        tick();
        chk("bp_rdy_low", 32'(bus.st_data_rdy), 0);
        chk("bp_out_hold", bus.st_data_out, 32'h40B00000);
        bus.st_data_out_pre_rdy = 1;
        tick();
        bus.st_data_out_rdy = 1;
        send(32'h3F800000, 1'b1);
        for (int k = 0; k < 4; k++) send(32'h3F800000, 1'b0);
        wait_res(11);
        chk_got(9, 32'h40B00000, 32'h40B00000, 1'b1);
        chk_got(10, 32'h40B00000, 32'h40B00000, 1'b0);

        // restart mid-vector
        for (int k = 0; k < 3; k++) send(32'h40000000, (k == 0));
        vec(32'h3F800000);
        wait_res(12);
        chk_got(11, 32'h40B00000, 32'h40B00000, 1'b0);

        // reset mid-vector
        for (int k = 0; k < 3; k++) send(32'h40000000, (k == 0));
        do_reset();
        chk("mid_rst_tap_address", 32'(bus.tap_address), 0);
        chk("mid_rst_bias_address", 32'(bus.bias_address), 0);
        load(32'h3F800000);
        for (int k = 0; k < 5; k++) send(32'h3F800000, 1'b0);
        wait_res(13);
        chk_got(12, 32'h40B00000, 32'h40B00000, 1'b1);

        // load_length 0 acts as 1; non-exact product exercises rounding
        do_reset();
        load(32'h3FAAAAAB);
        bus.load_length = 3'd0;
        send(32'h3FAAAAAB, 1'b0);
        send(32'h40400000, 1'b1);
        wait_res(15);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
